nibble_serial_subtractor: RTL and testbench
===========================================

// Module: nibble_serial_subtractor
// PURPOSE
//  Multi-cycle unsigned/two's-complement subtractor, D = A - B, for WIDTH-bit operands.
//  - Reuses one 4-bit carry-lookahead slice, one nibble per clock, LSB first.
//  - Subtraction is done as A + ~B + 1.
//  - Valid/ready handshake on the input and output sides, so it drops into the datapath in place of a wide combinational subtractor.
// PARAMETERS
//  WIDTH    16   operand/result width; multiple of 4, >= 4 (elaboration-time $error otherwise)
//  NIBBLES  WIDTH/4  derived localparam; number of RUN cycles
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands a, b valid
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  out_valid  out  1      diff/borrow/overflow valid (high only in DONE)
//  out_ready  in   1      consumer accepts result
//  diff       out  WIDTH  A - B modulo 2^WIDTH
//  borrow     out  1      1 when unsigned A < B (inverse of final carry-out)
//  overflow   out  1      signed overflow: (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB])
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - state=IDLE; diff, borrow, overflow, out_valid, the nibble index and the operand registers all 0.
//    - in_ready=1 on the first cycle after release.
//  - States:
//    - IDLE: in_ready=1. On in_valid&&in_ready at an edge:
//      - latch a, b; carry reg <= 1; nibble index k <= 0; diff <= 0; -> RUN.
//    - RUN: in_ready=0, out_valid=0. Each edge:
//      - slice inputs: X = A[4k+3:4k], Y = ~B[4k+3:4k], Cin = carry reg.
//      - diff[4k+3:4k] <= S; carry reg <= Cout; k <= k+1.
//      - on the edge processing k = NIBBLES-1: borrow <= ~Cout; overflow per the formula above; -> DONE.
//    - DONE: out_valid=1; diff/borrow/overflow held stable.
//      - on out_valid&&out_ready -> IDLE.
//      - new operands are not accepted in the same cycle; in_ready rises the following cycle.
//  - Latency: handshake at edge N -> out_valid high after edge N+NIBBLES (4 cycles for WIDTH=16).
//    Throughput: one result per NIBBLES+2 cycles at most.
//  - in_valid is ignored outside IDLE. a, b may change freely after the accepting edge.
//  - Under backpressure (out_ready=0) the block stays in DONE indefinitely; outputs do not change.
//  - Outputs in IDLE and RUN:
//    - diff/borrow/overflow keep their last values through IDLE.
//    - in RUN, diff is cleared at accept and filled nibble by nibble; consumers use it only while out_valid=1.
//  - Reset mid-RUN or mid-DONE: the operation is abandoned immediately and all outputs return to reset values.
//  - Wrap-around: the result is modulo 2^WIDTH; a borrow out of the MSB nibble is reported only via borrow.
//  - Index k width: $clog2(NIBBLES), minimum 1 bit.
// STRUCTURE
//  - Shared package:
//    - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
//    - NIBBLE_W=4.
//  - Sub-module: one instance of carry_lookahead_4bit (the team's 4-bit CLA slice) as the nibble datapath.
//  - This block adds only:
//    - FSM
//    - operand/result registers
//    - carry register
//    - nibble index
//    - nibble select and insert muxing
// TESTING (WIDTH=16)
//  1. a=16'h1234, b=16'h0034 -> diff=16'h1200, borrow=0, overflow=0; out_valid after exactly 4 cycles.
//  2. a=16'h1000, b=16'h0001 (borrow ripples across 3 nibbles) -> diff=16'h0FFF, borrow=0, overflow=0.
//     a=16'h0000, b=16'h0001 -> diff=16'hFFFF, borrow=1, overflow=0.
//  3. a=16'h8000, b=16'h0001 -> diff=16'h7FFF, borrow=0, overflow=1.
//     a=16'h7FFF, b=16'hFFFF -> diff=16'h8000, borrow=1, overflow=1.
//  4. Backpressure:
//     - out_ready=0 for 3 cycles after out_valid -> outputs stable and in_ready=0.
//     - in_valid pulsed with new operands during DONE is ignored.
//     - out_ready=1 -> IDLE; in_ready=1 next cycle.
//  5. Reset mid-RUN: rst_n=0 after 2 RUN edges of a=16'hFFFF, b=16'h0001
//     -> out_valid=0, diff=0, borrow=0, overflow=0 asynchronously; in_ready=1 after release.
//  6. Back-to-back: two transactions with in_valid held high, then a=b=16'hABCD
//     -> diff=0, borrow=0, overflow=0; second result matches model; no stale nibbles from the first.

Source files
------------

// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared constants and the FSM state type for the nibble-serial subtractor.
package nibble_serial_subtractor_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/nibble_serial_subtractor_cla.sv
// 4-bit carry-lookahead adder slice: s = x + y + cin, with carry-out.
module carry_lookahead_4bit
   import nibble_serial_subtractor_pkg::*;
(
   input  logic [NIBBLE_W-1:0] x,
   input  logic [NIBBLE_W-1:0] y,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] s,
   output logic                cout
);

   logic [NIBBLE_W-1:0] g;
   logic [NIBBLE_W-1:0] p;
   logic [NIBBLE_W:0]   c;

   assign g = x & y;
   assign p = x ^ y;

   // Every carry is a flat sum of generate/propagate terms, no ripple.
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

   assign s    = p ^ c[NIBBLE_W-1:0];
   assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor D = A - B: one shared 4-bit CLA slice, one nibble per clock, LSB first.
module nibble_serial_subtractor
   import nibble_serial_subtractor_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             overflow
);

   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int KW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

   generate
      if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
         $error("nibble_serial_subtractor: WIDTH must be a multiple of 4 and >= 4");
      end
   endgenerate

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
   state_t              state;
   state_t              state_next;
   logic [WIDTH-1:0]    a_q;
   logic [WIDTH-1:0]    b_q;
   logic                carry_q;
   logic [KW-1:0]       k_q;
   logic [NIBBLE_W-1:0] x;
   logic [NIBBLE_W-1:0] y;
   logic [NIBBLE_W-1:0] s;
   logic                cout;
   logic                accept;
   logic                last;

   assign x      = a_q[k_q*NIBBLE_W +: NIBBLE_W];
   assign y      = ~b_q[k_q*NIBBLE_W +: NIBBLE_W];
   assign accept = in_valid && in_ready;
   assign last   = (k_q == K_LAST);

   carry_lookahead_4bit u_cla (
      .x    (x),
      .y    (y),
      .cin  (carry_q),
      .s    (s),
      .cout (cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = ST_RUN;
         end
         ST_RUN: begin
            if (last) state_next = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Carry starts at 1 so that A + ~B + 1 yields A - B.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         carry_q  <= 1'b0;
         k_q      <= '0;
         diff     <= '0;
         borrow   <= 1'b0;
         overflow <= 1'b0;
      end else if (accept) begin
         a_q     <= a;
         b_q     <= b;
         carry_q <= 1'b1;
         k_q     <= '0;
         diff    <= '0;
      end else if (state == ST_RUN) begin
         diff[k_q*NIBBLE_W +: NIBBLE_W] <= s;
         carry_q <= cout;
         k_q     <= k_q + KW'(1);
         if (last) begin
            borrow   <= ~cout;
            overflow <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (s[NIBBLE_W-1] != a_q[WIDTH-1]);
         end
      end
   end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed bench for nibble_serial_subtractor (WIDTH=16) with an arithmetic reference model.
module tb_nibble_serial_subtractor;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b1;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] diff;
   logic         borrow;
   logic         overflow;

   int n_checks = 0;
   int n_pass   = 0;
   logic [W+1:0] exp_q[$];

   nibble_serial_subtractor #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borrow    (borrow),
      .overflow  (overflow)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- model: {borrow, overflow, diff} ----------------
   function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv);
      int ua, ub, sa, sb, sr, ud;
      logic brw, ovf;
      logic [W-1:0] d;
      ua  = int'(av);
      ub  = int'(bv);
      sa  = int'($signed(av));
      sb  = int'($signed(bv));
      ud  = (ua - ub) & 32'h0000_FFFF;
      d   = ud[W-1:0];
      brw = (ua < ub);
      sr  = sa - sb;
      ovf = (sr > 32767) || (sr < -32768);
      return {brw, ovf, d};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
   endtask

   // ---------------- scoreboard compare ----------------
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_result: out_valid=1 with nothing pending, diff=%0h (t=%0t)", diff, $time);
         end else begin
            check("model_result", {14'd0, borrow, overflow, diff}, {14'd0, exp_q[0]});
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_accept();
      int t;
      t = 0;
      while (!in_ready && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (!in_ready) check("in_ready_timeout", in_ready, 1);
      @(posedge clk); #1;
   endtask

   task automatic start(input logic [W-1:0] av, input logic [W-1:0] bv);
      a = av;
      b = bv;
      in_valid = 1'b1;
      wait_accept();
      exp_q.push_back(model(av, bv));
      in_valid = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
         if (!out_valid) check("in_ready_in_run", in_ready, 0);
      end
      if (!out_valid) check("out_valid_timeout", out_valid, 1);
   endtask

   task automatic run_vec(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] ed, input logic eb, input logic eo);
      int cyc;
      check({name, "_model_pin"}, {14'd0, model(av, bv)}, {14'd0, eb, eo, ed});
      out_ready = 1'b1;
      start(av, bv);
      wait_done(cyc);
      check({name, "_latency"}, cyc, 4);
      check({name, "_diff"}, diff, ed);
      check({name, "_borrow"}, borrow, eb);
      check({name, "_overflow"}, overflow, eo);
      @(posedge clk); #1;
      check({name, "_in_ready_after"}, in_ready, 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int cyc;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_diff", diff, 0);
      check("rst_borrow", borrow, 0);
      check("rst_overflow", overflow, 0);
      rst_n = 1'b1;
      check("rst_in_ready", in_ready, 1);
      @(posedge clk); #1;

      // basic, ripple, wrap-around and signed-overflow vectors
      run_vec("t1", 16'h1234, 16'h0034, 16'h1200, 1'b0, 1'b0);
      run_vec("t2a", 16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0);
      run_vec("t2b", 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
      run_vec("t3a", 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
      run_vec("t3b", 16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1);

      // reset mid-RUN abandons the operation
      start(16'hFFFF, 16'h0001);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("midrun_out_valid", out_valid, 0);
      check("midrun_diff", diff, 0);
      check("midrun_borrow", borrow, 0);
      check("midrun_overflow", overflow, 0);
      #2;
      rst_n = 1'b1;
      check("midrun_in_ready", in_ready, 1);
      @(posedge clk); #1;
      check("midrun_idle_out_valid", out_valid, 0);

      // backpressure, with an ignored in_valid pulse during DONE
      out_ready = 1'b0;
      check("bp_model_pin", {14'd0, model(16'h5555, 16'hAAAA)}, {14'd0, 1'b1, 1'b1, 16'hAAAB});
      start(16'h5555, 16'hAAAA);
      wait_done(cyc);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("bp_out_valid", out_valid, 1);
         check("bp_in_ready", in_ready, 0);
         check("bp_diff", diff, 16'hAAAB);
         if (i == 1) begin
            in_valid = 1'b1;
            a = 16'h0001;
            b = 16'h0001;
         end else begin
            in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_out_valid", out_valid, 0);
      check("bp_release_in_ready", in_ready, 1);
      @(posedge clk); #1;
      check("bp_pulse_ignored", in_ready, 1);

      // back-to-back with in_valid held high
      out_ready = 1'b1;
      a = 16'h4321;
      b = 16'h1234;
      in_valid = 1'b1;
      wait_accept();
      exp_q.push_back(model(16'h4321, 16'h1234));
      a = 16'h0F0F;
      b = 16'hF0F0;
      wait_accept();
      exp_q.push_back(model(16'h0F0F, 16'hF0F0));
      a = 16'hABCD;
      b = 16'hABCD;
      wait_accept();
      exp_q.push_back(model(16'hABCD, 16'hABCD));
      in_valid = 1'b0;
      wait_done(cyc);
      check("b2b_latency", cyc, 4);
      check("b2b_diff", diff, 16'h0000);
      check("b2b_borrow", borrow, 0);
      check("b2b_overflow", overflow, 0);
      check("b2b_pin_second", {14'd0, model(16'h0F0F, 16'hF0F0)}, {14'd0, 1'b1, 1'b0, 16'h1E1F});
      repeat (3) @(posedge clk);
      #1;
      check("queue_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
